// File: rtl/div_iter_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU: 33-cycle latency (2 for divide-by-zero).
// No input backpressure: start is taken only when idle, and ready is a one-cycle pulse with no hold.
module div_iter_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_div,
    input  logic                 annul,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 ready,
    output logic [2*WIDTH-1:0]   result,
    output logic                 div_by_zero
);

    typedef enum logic [1:0] {S_IDLE, S_ZERO, S_RUN, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     rem_q, rem_d;
    logic [WIDTH-1:0]     quo_q, quo_d;
    logic [WIDTH-1:0]     dvs_q, dvs_d;
    logic                 sdiv_q, sdiv_d;
    logic                 sgn_quo_q, sgn_quo_d;
    logic                 sgn_rem_q, sgn_rem_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic                 dbz_q, dbz_d;

    logic [WIDTH:0]       shifted;
    logic [WIDTH+1:0]     trial;
    logic                 take_sub;
    logic [WIDTH-1:0]     step_rem, step_quo;
    logic [WIDTH-1:0]     abs_a, abs_b;
    logic [WIDTH-1:0]     fin_quo, fin_rem;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        sdiv_d    = sdiv_q;
        sgn_quo_d = sgn_quo_q;
        sgn_rem_d = sgn_rem_q;
        result_d  = result_q;
        dbz_d     = dbz_q;

        // Shifted partial remainder needs WIDTH+1 bits; one more bit exposes the borrow.
        shifted  = {rem_q, quo_q[WIDTH-1]};
        trial    = {1'b0, shifted} - {2'b00, dvs_q};
        take_sub = ~trial[WIDTH+1];
        step_rem = take_sub ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
        step_quo = {quo_q[WIDTH-2:0], take_sub};

        // Magnitude of the most negative value is the same bit pattern read as unsigned.
        abs_a   = (signed_div && a[WIDTH-1]) ? ('0 - a) : a;
        abs_b   = (signed_div && b[WIDTH-1]) ? ('0 - b) : b;
        fin_quo = (sdiv_q && sgn_quo_q) ? ('0 - step_quo) : step_quo;
        fin_rem = (sdiv_q && sgn_rem_q) ? ('0 - step_rem) : step_rem;

        case (state_q)
            S_IDLE: begin
                if (start && !annul) begin
                    sdiv_d    = signed_div;
                    sgn_quo_d = a[WIDTH-1] ^ b[WIDTH-1];
                    sgn_rem_d = a[WIDTH-1];
                    cnt_d     = '0;
                    rem_d     = '0;
                    dvs_d     = abs_b;
                    if (b == '0) begin
                        quo_d   = a;
                        state_d = S_ZERO;
                    end else begin
                        quo_d   = abs_a;
                        state_d = S_RUN;
                    end
                end
            end
            S_ZERO: begin
                if (annul) begin
                    state_d = S_IDLE;
                end else begin
                    result_d = {quo_q, {WIDTH{1'b1}}};
                    dbz_d    = 1'b1;
                    state_d  = S_DONE;
                end
            end
            S_RUN: begin
                if (annul) begin
                    state_d = S_IDLE;
                end else begin
                    rem_d = step_rem;
                    quo_d = step_quo;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH-1)) begin
                        result_d = {fin_rem, fin_quo};
                        dbz_d    = 1'b0;
                        state_d  = S_DONE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            sdiv_q    <= 1'b0;
            sgn_quo_q <= 1'b0;
            sgn_rem_q <= 1'b0;
            result_q  <= '0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            sdiv_q    <= sdiv_d;
            sgn_quo_q <= sgn_quo_d;
            sgn_rem_q <= sgn_rem_d;
            result_q  <= result_d;
            dbz_q     <= dbz_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign ready       = (state_q == S_DONE);
    assign result      = result_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_iter_unit.sv
// Scoreboard bench for div_iter_unit: directed divides, latency, annul, reset and back-to-back cases.
module tb_div_iter_unit;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic           start, signed_div, annul;
    logic [W-1:0]   a, b;
    logic           busy, ready, div_by_zero;
    logic [2*W-1:0] result;

    int tests = 0;
    int fails = 0;
    logic [2*W:0] sb[$];
    logic [2*W-1:0] last_res;
    logic           last_dbz;

    div_iter_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .start(start), .signed_div(signed_div), .annul(annul),
        .a(a), .b(b), .busy(busy), .ready(ready), .result(result), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every ready pulse consumes one expected entry.
    initial begin
        logic [2*W:0] e;
        forever begin
            @(negedge clk);
            if (!rst && ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_ready", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("result", result, e[2*W-1:0]);
                    chk("div_by_zero", {63'd0, div_by_zero}, {63'd0, e[2*W]});
                end
            end
        end
    end

    task automatic start_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic sd);
        @(posedge clk); #1;
        start = 1'b1; a = ia; b = ib; signed_div = sd;
        @(posedge clk); #1;
        start = 1'b0; a = 32'hDEADBEEF; b = 32'h00000055; signed_div = ~sd;
    endtask

    task automatic expect_res(input logic [W-1:0] q, input logic [W-1:0] r, input logic dbz);
        sb.push_back({dbz, r, q});
        last_res = {r, q};
        last_dbz = dbz;
    endtask

    task automatic wait_ready(input int start_cyc, output int lat, output int bcnt);
        lat  = -1;
        bcnt = 0;
        for (int c = start_cyc + 1; c <= start_cyc + 60; c++) begin
            @(negedge clk);
            if (busy) bcnt++;
            if (ready) begin
                lat = c;
                break;
            end
        end
        if (lat < 0) chk("ready_timeout", 64'd1, 64'd0);
    endtask

    task automatic do_div(input string name, input logic [W-1:0] ia, input logic [W-1:0] ib,
                          input logic sd, input logic [W-1:0] q, input logic [W-1:0] r,
                          input logic dbz, input int exp_lat);
        int lat, bcnt;
        expect_res(q, r, dbz);
        start_op(ia, ib, sd);
        wait_ready(0, lat, bcnt);
        chk({name, "_latency"}, 64'(lat), 64'(exp_lat));
        chk({name, "_busy_cycles"}, 64'(bcnt), 64'(exp_lat));
        @(negedge clk);
        chk({name, "_ready_single"}, {63'd0, ready}, 64'd0);
        chk({name, "_idle_after"}, {63'd0, busy}, 64'd0);
    endtask

    task automatic quiet_window(input string name, input int n);
        int cnt;
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (ready) cnt++;
        end
        chk(name, 64'(cnt), 64'd0);
    endtask

    initial begin
        int lat, bcnt;
        rst = 1'b1; start = 1'b0; annul = 1'b0; signed_div = 1'b0; a = '0; b = '0;
        last_res = '0; last_dbz = 1'b0;
        #23 rst = 1'b0;
        @(negedge clk);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_ready", {63'd0, ready}, 64'd0);
        chk("reset_result", result, 64'd0);
        chk("reset_dbz", {63'd0, div_by_zero}, 64'd0);

        do_div("divu_big", 32'hFFFFFFFF, 32'h00000010, 1'b0, 32'h0FFFFFFF, 32'h0000000F, 1'b0, 33);

        // Reset in the middle of a run discards everything, including the held result.
        start_op(32'd5000, 32'd3, 1'b0);
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("rst_mid_busy", {63'd0, busy}, 64'd0);
        chk("rst_mid_result", result, 64'd0);
        chk("rst_mid_dbz", {63'd0, div_by_zero}, 64'd0);
        #5 rst = 1'b0;
        do_div("divu_100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 33);

        do_div("div_m7_2", 32'hFFFFFFF9, 32'd2, 1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 33);
        do_div("div_7_m2", 32'd7, 32'hFFFFFFFE, 1'b1, 32'hFFFFFFFD, 32'd1, 1'b0, 33);
        do_div("div_m7_m2", 32'hFFFFFFF9, 32'hFFFFFFFE, 1'b1, 32'd3, 32'hFFFFFFFF, 1'b0, 33);
        do_div("div_min_m1", 32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'd0, 1'b0, 33);
        do_div("divu_min_3", 32'h80000000, 32'd3, 1'b0, 32'h2AAAAAAA, 32'd2, 1'b0, 33);
        do_div("div_min_3", 32'h80000000, 32'd3, 1'b1, 32'hD5555556, 32'hFFFFFFFE, 1'b0, 33);

        do_div("div_zero", 32'h12345678, 32'd0, 1'b1, 32'hFFFFFFFF, 32'h12345678, 1'b1, 2);
        do_div("dbz_clear", 32'd1000, 32'd10, 1'b0, 32'd100, 32'd0, 1'b0, 33);

        // A start pulse while running must not disturb the operation in flight.
        expect_res(32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0);
        start_op(32'hFFFFFFF9, 32'd2, 1'b1);
        repeat (4) @(posedge clk);
        #1 start = 1'b1; a = 32'd1000; b = 32'd10; signed_div = 1'b0;
        @(posedge clk);
        #1 start = 1'b0;
        wait_ready(5, lat, bcnt);
        chk("busy_start_latency", 64'(lat), 64'd33);
        quiet_window("busy_start_no_extra", 40);

        // Annul during RUN: back to idle on the next edge, result untouched.
        start_op(32'd12345, 32'd5, 1'b0);
        repeat (14) @(posedge clk);
        #1 annul = 1'b1;
        @(posedge clk);
        #1 annul = 1'b0;
        chk("annul_idle", {63'd0, busy}, 64'd0);
        quiet_window("annul_no_ready", 40);
        chk("annul_result_kept", result, last_res);
        chk("annul_dbz_kept", {63'd0, div_by_zero}, {63'd0, last_dbz});

        // start together with annul in IDLE is refused.
        @(posedge clk);
        #1 start = 1'b1; annul = 1'b1; a = 32'd77; b = 32'd7; signed_div = 1'b0;
        @(posedge clk);
        #1 start = 1'b0; annul = 1'b0;
        chk("start_annul_idle", {63'd0, busy}, 64'd0);
        quiet_window("start_annul_no_ready", 40);

        // Back-to-back: start raised in the DONE cycle is taken one cycle later.
        expect_res(32'd14, 32'd2, 1'b0);
        start_op(32'd100, 32'd7, 1'b0);
        wait_ready(0, lat, bcnt);
        chk("b2b_first_latency", 64'(lat), 64'd33);
        start = 1'b1; a = 32'hFFFFFFF9; b = 32'hFFFFFFFE; signed_div = 1'b1;
        expect_res(32'd3, 32'hFFFFFFFF, 1'b0);
        @(posedge clk);
        #1 chk("b2b_done_start_ignored", {63'd0, busy}, 64'd0);
        @(posedge clk);
        #1 start = 1'b0; a = 32'hDEADBEEF; b = 32'd1;
        chk("b2b_second_accepted", {63'd0, busy}, 64'd1);
        wait_ready(0, lat, bcnt);
        chk("b2b_second_latency", 64'(lat), 64'd33);
        repeat (3) @(negedge clk);

        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
